lock_supervisor: RTL and testbench
==================================

# lock_supervisor

Attempt controller for the four-button combination lock. It consumes the single-cycle press pulses from the existing push-button detectors. It compares each complete four-press entry against a programmable code register, counts failed entries, and enforces a timed lockout. It also auto-relocks after a hold period and lets an unlocked user reprogram the code.

## Interface
Parameters:
- MAX_FAILS, 3: consecutive failed entries that trigger lockout (1..3)
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles
- UNLOCK_CYCLES, 500: duration `unlocked` stays high
- ENTRY_TIMEOUT, 200: idle cycles allowed between presses during ENTRY/PROGRAM
- DEFAULT_CODE, 8'h27: reset code; digit k in bits [2k+1:2k]; button index A=0,B=1,C=2,D=3. The default sequence is D,B,C,A.

Ports:
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset
- btn_pulse  in  4  press pulses [0]=A..[3]=D, one cycle each, synchronous to clk
- prog_req  in  1  level; request code programming (honoured only in UNLOCKED)
- unlocked  out  1  high in UNLOCKED
- locked_out  out  1  high in LOCKOUT
- programming  out  1  high in PROGRAM
- prog_done  out  1  one-cycle pulse when a new code is committed
- fail_cnt  out  2  current consecutive-failure count

## Operation
- Press classification:
  - btn_pulse == 0: no event.
  - Exactly one bit set: valid press of that index.
  - More than one bit set: malformed press.
- Reset (any time, including mid-entry):
  - state = IDLE, code = DEFAULT_CODE, fail_cnt = 0, digit index = 0, mismatch flag = 0.
  - All outputs 0.
- States: IDLE, ENTRY, UNLOCKED, PROGRAM, LOCKOUT.
- IDLE:
  - Any press (valid or malformed) is digit 0.
  - Set mismatch = (press is not one-hot) or (index != code digit 0); idx = 1; go to ENTRY.
- ENTRY:
  - Each press ORs into mismatch and increments idx.
  - On the 4th press:
    - mismatch = 0: go to UNLOCKED, fail_cnt = 0.
    - Otherwise fail_cnt++. If the new count equals MAX_FAILS, go to LOCKOUT; else go to IDLE.
  - There is no early rejection. The verdict comes only after 4 presses, so a partial entry leaks nothing.
  - Timeout (ENTRY_TIMEOUT cycles with no press): go to IDLE, fail_cnt unchanged.
- UNLOCKED:
  - Button presses are ignored.
  - Hold timer expiry goes to IDLE.
  - prog_req = 1 with no expiry that cycle goes to PROGRAM.
  - Expiry wins over a simultaneous prog_req.
- PROGRAM:
  - Valid presses fill a shadow register at digit idx.
  - A malformed press aborts to IDLE with the code unchanged.
  - On the 4th valid press: code <= shadow, prog_done pulse, go to IDLE (relock).
  - Timeout: go to IDLE, code unchanged.
  - prog_req is not examined here.
- LOCKOUT:
  - All presses are ignored.
  - After LOCKOUT_CYCLES, go to IDLE with fail_cnt = 0.
- fail_cnt saturates at MAX_FAILS; it never wraps.

## Timing
- Moore outputs, all registered, driven from the current state.
- Press latency: a press sampled at edge N changes state at edge N. A 4th correct press at edge N gives unlocked = 1 for the cycle after N.
- UNLOCKED lasts exactly UNLOCK_CYCLES cycles. LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- Timer load rules:
  - The timer loads on every state entry.
  - It reloads on every press in ENTRY/PROGRAM.
  - Its expiry is evaluated in the same cycle as any press; a press in the expiry cycle counts and reloads.
- Entry timeout: the last press is at edge N and no press follows. State is IDLE for the cycle after edge N+ENTRY_TIMEOUT.
- prog_done is high for exactly the first cycle in IDLE after a commit.
- A press arriving in the same cycle as a state transition into ENTRY/PROGRAM belongs to the transition. It is never double-counted.

## Structure
- Package lock_pkg holds:
  - State enumeration (3-bit: IDLE=0, ENTRY=1, UNLOCKED=2, PROGRAM=3, LOCKOUT=4).
  - Button index constants BTN_A..BTN_D.
  - DIGIT_W=2 and CODE_LEN=4.
  - A one-hot-to-index function with a malformed flag.
- One sub-module, lock_timer: loadable down-counter.
  - Inputs: clk, rst_n, load, load_val.
  - Output: expired.
  - Width: $clog2 of the largest cycle parameter.
  - Shared across states.
- Push-button detectors stay outside this block.

## Test plan
- Reset, then pulse D,B,C,A with gaps of 5 cycles -> unlocked = 1 for exactly 500 cycles, fail_cnt = 0, then IDLE.
- Enter D,B,A,A three times -> fail_cnt goes 1,2,3; locked_out = 1 for 1000 cycles; presses ignored during lockout; then fail_cnt = 0.
- Enter D,B then wait 200 cycles -> back to IDLE with fail_cnt unchanged; next full correct entry unlocks.
- Unlock, assert prog_req, enter A,A,B,B -> prog_done pulse, code = 8'h50. Old sequence D,B,C,A then fails; A,A,B,B unlocks.
- Press D with B simultaneously (4'b1010) as digit 0, then B,C,A -> counts as failure, fail_cnt = 1.
- Assert rst_n low mid-PROGRAM after 2 presses -> code returns to 8'h27, all outputs 0; D,B,C,A unlocks.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock supervisor: state codes,
// button indices, code geometry and press decoding.
package lock_pkg;

    localparam int DIGIT_W  = 2;
    localparam int CODE_LEN = 4;
    localparam int CODE_W   = DIGIT_W * CODE_LEN;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ENTRY    = 3'd1;
    localparam logic [2:0] ST_UNLOCKED = 3'd2;
    localparam logic [2:0] ST_PROGRAM  = 3'd3;
    localparam logic [2:0] ST_LOCKOUT  = 3'd4;

    localparam logic [DIGIT_W-1:0] BTN_A = 2'd0;
    localparam logic [DIGIT_W-1:0] BTN_B = 2'd1;
    localparam logic [DIGIT_W-1:0] BTN_C = 2'd2;
    localparam logic [DIGIT_W-1:0] BTN_D = 2'd3;

    typedef struct packed {
        logic               malformed;
        logic [DIGIT_W-1:0] idx;
    } press_t;

    // Anything other than exactly one set bit is flagged malformed.
    function automatic press_t decode_press(input logic [3:0] btn);
        press_t p;
        p.malformed = 1'b0;
        p.idx       = BTN_A;
        case (btn)
            4'b0001: p.idx = BTN_A;
            4'b0010: p.idx = BTN_B;
            4'b0100: p.idx = BTN_C;
            4'b1000: p.idx = BTN_D;
            default: p.malformed = 1'b1;
        endcase
        return p;
    endfunction

    function automatic logic [DIGIT_W-1:0] digit_of(input logic [CODE_W-1:0] code,
                                                     input logic [1:0]        k);
        return code[k*DIGIT_W +: DIGIT_W];
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by every timed state of the supervisor;
// expired is high while the count sits at zero.
module lock_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign expired = (count == '0);

endmodule

// File: rtl/lock_supervisor.sv
// Attempt controller for the four-button lock: entry checking, failure
// counting with timed lockout, auto-relock and code reprogramming.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int               MAX_FAILS      = 3,
    parameter int               LOCKOUT_CYCLES = 1000,
    parameter int               UNLOCK_CYCLES  = 500,
    parameter int               ENTRY_TIMEOUT  = 200,
    parameter logic [CODE_W-1:0] DEFAULT_CODE  = 8'h27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_pulse,
    input  logic       prog_req,
    output logic       unlocked,
    output logic       locked_out,
    output logic       programming,
    output logic       prog_done,
    output logic [1:0] fail_cnt
);

    localparam int MAX_CYC_A = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int MAX_CYC   = (MAX_CYC_A > ENTRY_TIMEOUT) ? MAX_CYC_A : ENTRY_TIMEOUT;
    localparam int TW        = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [1:0] MAX_F    = 2'(MAX_FAILS);
    localparam logic [1:0] LAST_IDX = 2'(CODE_LEN - 1);

    logic [2:0]        state, next_state;
    logic [1:0]        idx, next_idx;
    logic              mismatch, next_mismatch;
    logic [1:0]        next_fail, fail_inc;
    logic [CODE_W-1:0] code, next_code, shadow, next_shadow;
    logic              commit, press_reload, bad;
    logic              any_press, expired, tmr_load;
    logic [TW-1:0]     tmr_val;
    press_t            p;

    assign any_press = |btn_pulse;
    assign p         = decode_press(btn_pulse);
    assign fail_inc  = (fail_cnt == MAX_F) ? fail_cnt : fail_cnt + 2'd1;
    assign bad       = mismatch | p.malformed | (p.idx != digit_of(code, idx));

    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        next_state    = state;
        next_idx      = idx;
        next_mismatch = mismatch;
        next_fail     = fail_cnt;
        next_code     = code;
        next_shadow   = shadow;
        commit        = 1'b0;
        press_reload  = 1'b0;
        case (state)
            ST_IDLE: if (any_press) begin
                next_mismatch = p.malformed | (p.idx != digit_of(code, 2'd0));
                next_idx      = 2'd1;
                next_state    = ST_ENTRY;
            end
            ST_ENTRY: if (any_press) begin
                press_reload = 1'b1;
                if (idx == LAST_IDX) begin
                    next_idx = 2'd0;
                    if (!bad) begin
                        next_fail  = 2'd0;
                        next_state = ST_UNLOCKED;
                    end else begin
                        next_fail  = fail_inc;
                        next_state = (fail_inc == MAX_F) ? ST_LOCKOUT : ST_IDLE;
                    end
                end else begin
                    next_mismatch = bad;
                    next_idx      = idx + 2'd1;
                end
            end else if (expired) begin
                next_idx   = 2'd0;
                next_state = ST_IDLE;
            end
            // Hold expiry takes priority over a programming request.
            ST_UNLOCKED: if (expired) begin
                next_state = ST_IDLE;
            end else if (prog_req) begin
                next_idx   = 2'd0;
                next_state = ST_PROGRAM;
            end
            ST_PROGRAM: if (any_press) begin
                next_idx = 2'd0;
                if (p.malformed) begin
                    next_state = ST_IDLE;
                end else begin
                    press_reload = 1'b1;
                    next_shadow[idx*DIGIT_W +: DIGIT_W] = p.idx;
                    if (idx == LAST_IDX) begin
                        next_code  = next_shadow;
                        commit     = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        next_idx = idx + 2'd1;
                    end
                end
            end else if (expired) begin
                next_idx   = 2'd0;
                next_state = ST_IDLE;
            end
            ST_LOCKOUT: if (expired) begin
                next_fail  = 2'd0;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Load value is one less than the dwell because expiry is seen on count 0.
    always_comb begin
        tmr_load = (next_state != state) | press_reload;
        case (next_state)
            ST_ENTRY, ST_PROGRAM: tmr_val = TW'(ENTRY_TIMEOUT - 1);
            ST_UNLOCKED:          tmr_val = TW'(UNLOCK_CYCLES - 1);
            ST_LOCKOUT:           tmr_val = TW'(LOCKOUT_CYCLES - 1);
            default:              tmr_val = '0;
        endcase
    end

    lock_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= 2'd0;
            mismatch    <= 1'b0;
            fail_cnt    <= 2'd0;
            code        <= DEFAULT_CODE;
            shadow      <= '0;
            unlocked    <= 1'b0;
            locked_out  <= 1'b0;
            programming <= 1'b0;
            prog_done   <= 1'b0;
        end else begin
            state       <= next_state;
            idx         <= next_idx;
            mismatch    <= next_mismatch;
            fail_cnt    <= next_fail;
            code        <= next_code;
            shadow      <= next_shadow;
            unlocked    <= (next_state == ST_UNLOCKED);
            locked_out  <= (next_state == ST_LOCKOUT);
            programming <= (next_state == ST_PROGRAM);
            prog_done   <= commit;
        end
    end

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed self-checking bench for lock_supervisor with default parameters.
module tb_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn_pulse;
    logic       prog_req;
    logic       unlocked, locked_out, programming, prog_done;
    logic [1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [3:0] A = 4'b0001, B = 4'b0010, C = 4'b0100, D = 4'b1000;

    lock_supervisor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_pulse   (btn_pulse),
        .prog_req    (prog_req),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .programming (programming),
        .prog_done   (prog_done),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle pulse, sampled by exactly one rising edge; returns at the
    // falling edge right after that sampling edge.
    task automatic press(input logic [3:0] b);
        @(negedge clk);
        btn_pulse = b;
        @(negedge clk);
        btn_pulse = 4'b0000;
    endtask

    task automatic enter(input logic [3:0] b0, b1, b2, b3);
        press(b0); press(b1); press(b2); press(b3);
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_pulse = 4'b0000;
        prog_req  = 1'b0;
        #12;
        check("rst_unlocked",    8'(unlocked),    8'd0);
        check("rst_locked_out",  8'(locked_out),  8'd0);
        check("rst_programming", 8'(programming), 8'd0);
        check("rst_prog_done",   8'(prog_done),   8'd0);
        check("rst_fail_cnt",    8'(fail_cnt),    8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Correct default code with gaps, hold window, ignored press, expiry vs prog_req.
        press(D); idle(5); press(B); idle(5); press(C); idle(5); press(A);
        check("t1_unlocked",   8'(unlocked), 8'd1);
        check("t1_fail_cnt",   8'(fail_cnt), 8'd0);
        idle(10); press(B);
        check("t1_press_ignored", 8'(unlocked), 8'd1);
        idle(487);
        check("t1_hold_last_cycle", 8'(unlocked), 8'd1);
        prog_req = 1'b1;
        idle(1);
        check("t1_expired",         8'(unlocked),    8'd0);
        check("t1_expiry_beats_req", 8'(programming), 8'd0);
        prog_req = 1'b0;

        // Three wrong entries -> lockout of exactly 1000 cycles.
        for (int r = 1; r <= 3; r++) begin
            enter(D, B, A, A);
            check("t2_fail_step", 8'(fail_cnt),   8'(r));
            check("t2_lock_step", 8'(locked_out), (r == 3) ? 8'd1 : 8'd0);
        end
        idle(100);
        enter(D, B, C, A);
        check("t2_lock_ignores_press", 8'(locked_out), 8'd1);
        check("t2_lock_no_unlock",     8'(unlocked),   8'd0);
        idle(891);
        check("t2_lock_last_cycle", 8'(locked_out), 8'd1);
        idle(1);
        check("t2_lock_released", 8'(locked_out), 8'd0);
        check("t2_fail_cleared",  8'(fail_cnt),   8'd0);

        // Partial entry times out; fresh correct entry then unlocks.
        press(D); press(B); idle(199);
        enter(D, B, C, A);
        check("t3_timeout_then_unlock", 8'(unlocked), 8'd1);
        check("t3_timeout_fail_cnt",    8'(fail_cnt), 8'd0);
        idle(500);
        // A press landing in the expiry cycle still counts.
        press(D); press(B); idle(198); press(C); press(A);
        check("t3_press_at_expiry", 8'(unlocked), 8'd1);
        idle(500);

        // Reprogram to A,A,B,B (8'h50).
        enter(D, B, C, A);
        prog_req = 1'b1;
        idle(1);
        check("t4_programming", 8'(programming), 8'd1);
        check("t4_left_unlocked", 8'(unlocked),  8'd0);
        prog_req = 1'b0;
        enter(A, A, B, B);
        check("t4_prog_done",   8'(prog_done),   8'd1);
        check("t4_prog_exit",   8'(programming), 8'd0);
        idle(1);
        check("t4_prog_done_1cyc", 8'(prog_done), 8'd0);
        enter(D, B, C, A);
        check("t4_old_code_fails", 8'(fail_cnt), 8'd1);
        check("t4_old_code_locked", 8'(unlocked), 8'd0);
        enter(A, A, B, B);
        check("t4_new_code_unlocks", 8'(unlocked), 8'd1);
        check("t4_new_code_fail_clr", 8'(fail_cnt), 8'd0);

        // Malformed press aborts programming without touching the code.
        prog_req = 1'b1;
        idle(1);
        prog_req = 1'b0;
        press(A); press(4'b0011);
        check("t4_abort_programming", 8'(programming), 8'd0);
        check("t4_abort_no_done",     8'(prog_done),   8'd0);
        enter(A, A, B, B);
        check("t4_abort_code_kept", 8'(unlocked), 8'd1);
        idle(500);

        // Malformed first digit is a failure.
        enter(4'b1010, B, C, A);
        check("t5_malformed_fail", 8'(fail_cnt), 8'd1);
        check("t5_malformed_lock", 8'(unlocked), 8'd0);

        // Reset mid-programming restores the default code.
        enter(A, A, B, B);
        prog_req = 1'b1;
        idle(1);
        prog_req = 1'b0;
        press(B); press(C);
        check("t6_in_program", 8'(programming), 8'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_unlocked",    8'(unlocked),    8'd0);
        check("t6_rst_locked_out",  8'(locked_out),  8'd0);
        check("t6_rst_programming", 8'(programming), 8'd0);
        check("t6_rst_prog_done",   8'(prog_done),   8'd0);
        check("t6_rst_fail_cnt",    8'(fail_cnt),    8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        enter(D, B, C, A);
        check("t6_default_code_back", 8'(unlocked), 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
